// File: rtl/servo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : servo_pkg
// Description : Shared definitions for the servo array controller. Holds the
//               CMD register encodings, register offsets, STATUS bit indices,
//               the channel state type and a CMD legality helper.
// Revision    : 1.0 - initial release
// ============================================================================
package servo_pkg;

  // CMD register encodings
  localparam logic [31:0] CMD_NEUTRAL  = 32'd1;
  localparam logic [31:0] CMD_FORWARD  = 32'd2;
  localparam logic [31:0] CMD_REVERSE  = 32'd3;
  localparam logic [31:0] CMD_ZERO_POS = 32'd4;
  localparam logic [31:0] CMD_RTZ      = 32'd5;

  // Per-channel register offsets (PADDR[3:0], PADDR[7] = 0)
  localparam logic [3:0] OFF_TARGET = 4'h0;
  localparam logic [3:0] OFF_CMD    = 4'h4;
  localparam logic [3:0] OFF_POS    = 4'h8;
  localparam logic [3:0] OFF_STATUS = 4'hC;

  // Global register offsets (PADDR[6:0], PADDR[7] = 1)
  localparam logic [6:0] GOFF_CTRL  = 7'h00;
  localparam logic [6:0] GOFF_FRAME = 7'h04;
  localparam logic [6:0] GOFF_SLEW  = 7'h08;

  // STATUS register bit positions
  localparam int STAT_RTZ_BUSY = 0;
  localparam int STAT_SLEWING  = 1;

  typedef enum logic [0:0] {
    ST_RUN = 1'b0,
    ST_RTZ = 1'b1
  } ch_state_e;

  function automatic logic cmd_valid(input logic [31:0] cmd);
    return (cmd >= CMD_NEUTRAL) && (cmd <= CMD_RTZ);
  endfunction

endpackage
`default_nettype wire

// File: rtl/servo_array_ctrl_channel.sv
`default_nettype none
// ============================================================================
// Module      : servo_channel
// Description : One servo channel: clamped target, frame-synchronous pulse
//               width with optional slew limit, saturating signed position
//               tracker, RUN/RTZ state machine and registered PWM compare.
// Ports       : clk, rst_n      - clock, async active-low reset
//               frame_cnt       - shared frame counter
//               boundary        - high in the last cycle of each frame
//               out_en          - global output enable
//               slew            - max pulse-width change per frame (0 = none)
//               tgt_we, cmd_we  - legal, committed TARGET / CMD writes
//               wdata           - APB write data
//               target, pos     - readback values
//               rtz_busy, slewing, pwm - status and PWM line
// Revision    : 1.0 - initial release
// ============================================================================
module servo_channel #(
  parameter int CNT_W      = 32,
  parameter int PW_NEUTRAL = 150000,
  parameter int PW_REVERSE = 100000,
  parameter int PW_FORWARD = 200000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [CNT_W-1:0]        frame_cnt,
  input  logic                    boundary,
  input  logic                    out_en,
  input  logic [CNT_W-1:0]        slew,
  input  logic                    tgt_we,
  input  logic                    cmd_we,
  input  logic [31:0]             wdata,
  output logic [CNT_W-1:0]        target,
  output logic signed [CNT_W-1:0] pos,
  output logic                    rtz_busy,
  output logic                    slewing,
  output logic                    pwm
);
  import servo_pkg::*;

  localparam logic [CNT_W-1:0]        PW_NEU  = CNT_W'(PW_NEUTRAL);
  localparam logic [CNT_W-1:0]        PW_REV  = CNT_W'(PW_REVERSE);
  localparam logic [CNT_W-1:0]        PW_FWD  = CNT_W'(PW_FORWARD);
  localparam logic signed [CNT_W-1:0] POS_MAX = {1'b0, {(CNT_W-1){1'b1}}};
  localparam logic signed [CNT_W-1:0] POS_MIN = {1'b1, {(CNT_W-1){1'b0}}};
  localparam logic signed [CNT_W-1:0] POS_ONE = CNT_W'(1);

  ch_state_e                state_q, state_d;
  logic [CNT_W-1:0]         target_q, target_d;
  logic [CNT_W-1:0]         cur_pw_q, cur_pw_d;
  logic signed [CNT_W-1:0]  pos_q, pos_d;
  logic                     pwm_q, pwm_d;
  logic [CNT_W-1:0]         clamp_pw;

  // Clamp on the full 32-bit write value so oversize data cannot wrap into range
  always_comb begin
    if (wdata < 32'(PW_REVERSE)) begin
      clamp_pw = PW_REV;
    end else if (wdata > 32'(PW_FORWARD)) begin
      clamp_pw = PW_FWD;
    end else begin
      clamp_pw = CNT_W'(wdata);
    end
  end

  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    cur_pw_d = cur_pw_q;
    pos_d    = pos_q;

    if (tgt_we) begin
      target_d = clamp_pw;
    end

    if (cmd_we) begin
      case (wdata)
        CMD_NEUTRAL: target_d = PW_NEU;
        CMD_FORWARD: target_d = PW_FWD;
        CMD_REVERSE: target_d = PW_REV;
        CMD_RTZ: begin
          // Already at zero: nothing to return from, stay in RUN
          if (pos_q != '0) begin
            state_d = ST_RTZ;
          end
        end
        default: ;
      endcase
    end

    if (boundary) begin
      if (state_q == ST_RUN) begin
        // A write landing in the boundary cycle still steers this frame
        if (slew == '0) begin
          cur_pw_d = target_d;
        end else if (target_d > cur_pw_q) begin
          cur_pw_d = (target_d - cur_pw_q > slew) ? cur_pw_q + slew : target_d;
        end else begin
          cur_pw_d = (cur_pw_q - target_d > slew) ? cur_pw_q - slew : target_d;
        end
      end else if (pos_q[CNT_W-1]) begin
        cur_pw_d = PW_FWD;
      end else if (pos_q != '0) begin
        cur_pw_d = PW_REV;
      end else begin
        cur_pw_d = PW_NEU;
        target_d = PW_NEU;
        state_d  = ST_RUN;
      end

      // Tracker follows the width that will be driven in the coming frame
      if ((cur_pw_d == PW_FWD) && (pos_q != POS_MAX)) begin
        pos_d = pos_q + POS_ONE;
      end else if ((cur_pw_d == PW_REV) && (pos_q != POS_MIN)) begin
        pos_d = pos_q - POS_ONE;
      end
    end

    // Explicit zeroing overrides a simultaneous tracker step
    if (cmd_we && (wdata == CMD_ZERO_POS)) begin
      pos_d = '0;
    end
  end

  // Registered compare: the line rises one cycle after the counter wraps
  always_comb begin
    pwm_d = out_en & (frame_cnt < cur_pw_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_RUN;
      target_q <= PW_NEU;
      cur_pw_q <= PW_NEU;
      pos_q    <= '0;
      pwm_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      cur_pw_q <= cur_pw_d;
      pos_q    <= pos_d;
      pwm_q    <= pwm_d;
    end
  end

  assign target   = target_q;
  assign pos      = pos_q;
  assign rtz_busy = (state_q == ST_RTZ);
  assign slewing  = (state_q == ST_RUN) && (cur_pw_q != target_q);
  assign pwm      = pwm_q;

endmodule
`default_nettype wire

// File: rtl/servo_array_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : servo_array_ctrl
// Description : APB3 slave controlling NUM_CH servo PWM channels from one
//               shared frame timer. Holds APB decode and readback, the frame
//               counter, and the CTRL / SLEW / FRAME registers.
// Ports       : PCLK, PRESERN             - clock, async active-low reset
//               PSEL, PENABLE, PWRITE,
//               PADDR, PWDATA             - APB3 request
//               PRDATA, PREADY, PSLVERR   - APB3 response
//               servo_pwm                 - one PWM line per channel
// Revision    : 1.0 - initial release
// ============================================================================
module servo_array_ctrl #(
  parameter int NUM_CH     = 2,
  parameter int CNT_W      = 32,
  parameter int PERIOD_CYC = 2000000,
  parameter int PW_NEUTRAL = 150000,
  parameter int PW_REVERSE = 100000,
  parameter int PW_FORWARD = 200000
) (
  input  logic              PCLK,
  input  logic              PRESERN,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [31:0]       PADDR,
  input  logic [31:0]       PWDATA,
  output logic [31:0]       PRDATA,
  output logic              PREADY,
  output logic              PSLVERR,
  output logic [NUM_CH-1:0] servo_pwm
);
  import servo_pkg::*;

  localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(PERIOD_CYC - 1);

  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic [31:0]      frame_q, frame_d;
  logic             out_en_q, out_en_d;
  logic [31:0]      slew_q, slew_d;
  logic             boundary;

  logic             is_glb;
  logic [2:0]       ch_idx;
  logic [3:0]       ch_off;
  logic [6:0]       g_off;
  logic             ch_ok;
  logic             access;
  logic             err;
  logic             wr_ok;
  logic [31:0]      rdata;

  logic [CNT_W-1:0]        ch_target [NUM_CH];
  logic signed [CNT_W-1:0] ch_pos    [NUM_CH];
  logic [NUM_CH-1:0]       ch_busy;
  logic [NUM_CH-1:0]       ch_slewing;
  logic [NUM_CH-1:0]       ch_tgt_we;
  logic [NUM_CH-1:0]       ch_cmd_we;

  logic [CNT_W-1:0]        sel_target;
  logic signed [CNT_W-1:0] sel_pos;
  logic                    sel_busy;
  logic                    sel_slewing;

  logic unused_addr_bits;
  assign unused_addr_bits = ^PADDR[31:8];

  assign boundary = (frame_cnt_q == FRAME_LAST);
  assign is_glb   = PADDR[7];
  assign ch_idx   = PADDR[6:4];
  assign ch_off   = PADDR[3:0];
  assign g_off    = PADDR[6:0];
  assign ch_ok    = (int'(ch_idx) < NUM_CH);
  assign access   = PSEL & PENABLE;

  // Select the addressed channel without indexing past NUM_CH
  always_comb begin
    sel_target  = '0;
    sel_pos     = '0;
    sel_busy    = 1'b0;
    sel_slewing = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_idx == 3'(i)) begin
        sel_target  = ch_target[i];
        sel_pos     = ch_pos[i];
        sel_busy    = ch_busy[i];
        sel_slewing = ch_slewing[i];
      end
    end
  end

  // Address decode: error flag and raw read data
  always_comb begin
    err   = 1'b0;
    rdata = '0;
    if (is_glb) begin
      case (g_off)
        GOFF_CTRL:  rdata = {31'b0, out_en_q};
        GOFF_FRAME: begin
          rdata = frame_q;
          err   = PWRITE;
        end
        GOFF_SLEW:  rdata = slew_q;
        default:    err   = 1'b1;
      endcase
    end else if (!ch_ok) begin
      err = 1'b1;
    end else begin
      case (ch_off)
        OFF_TARGET: begin
          rdata = 32'(sel_target);
          err   = PWRITE & sel_busy;
        end
        OFF_CMD: begin
          err = PWRITE & (sel_busy | !cmd_valid(PWDATA));
        end
        OFF_POS: begin
          rdata = 32'(sel_pos);
          err   = PWRITE;
        end
        OFF_STATUS: begin
          rdata[STAT_RTZ_BUSY] = sel_busy;
          rdata[STAT_SLEWING]  = sel_slewing;
          err                  = PWRITE;
        end
        default: err = 1'b1;
      endcase
    end
  end

  assign PRDATA  = (PSEL && !PWRITE && !err) ? rdata : 32'b0;
  assign PSLVERR = access & err;
  assign PREADY  = 1'b1;
  assign wr_ok   = access & PWRITE & !err;

  always_comb begin
    frame_cnt_d = boundary ? '0 : frame_cnt_q + CNT_W'(1);
    frame_d     = boundary ? frame_q + 32'd1 : frame_q;
    out_en_d    = out_en_q;
    slew_d      = slew_q;
    if (wr_ok && is_glb && (g_off == GOFF_CTRL)) begin
      out_en_d = PWDATA[0];
    end
    if (wr_ok && is_glb && (g_off == GOFF_SLEW)) begin
      slew_d = PWDATA;
    end
  end

  always_ff @(posedge PCLK or negedge PRESERN) begin
    if (!PRESERN) begin
      frame_cnt_q <= '0;
      frame_q     <= '0;
      out_en_q    <= 1'b1;
      slew_q      <= '0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
      frame_q     <= frame_d;
      out_en_q    <= out_en_d;
      slew_q      <= slew_d;
    end
  end

  generate
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      assign ch_tgt_we[i] = wr_ok & !is_glb & (ch_idx == 3'(i)) & (ch_off == OFF_TARGET);
      assign ch_cmd_we[i] = wr_ok & !is_glb & (ch_idx == 3'(i)) & (ch_off == OFF_CMD);

      servo_channel #(
        .CNT_W      (CNT_W),
        .PW_NEUTRAL (PW_NEUTRAL),
        .PW_REVERSE (PW_REVERSE),
        .PW_FORWARD (PW_FORWARD)
      ) u_channel (
        .clk       (PCLK),
        .rst_n     (PRESERN),
        .frame_cnt (frame_cnt_q),
        .boundary  (boundary),
        .out_en    (out_en_q),
        .slew      (CNT_W'(slew_q)),
        .tgt_we    (ch_tgt_we[i]),
        .cmd_we    (ch_cmd_we[i]),
        .wdata     (PWDATA),
        .target    (ch_target[i]),
        .pos       (ch_pos[i]),
        .rtz_busy  (ch_busy[i]),
        .slewing   (ch_slewing[i]),
        .pwm       (servo_pwm[i])
      );
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_servo_array_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_servo_array_ctrl
// Description : Self-checking bench for servo_array_ctrl. Expected pulse
//               widths are queued per frame as stimulus is issued and checked
//               when each frame's pulses have been measured; register reads
//               and error responses are checked inline.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_servo_array_ctrl;

  localparam int NUM_CH = 2;
  localparam int CNT_W  = 32;
  localparam int PERIOD = 100;
  localparam int PW_N   = 15;
  localparam int PW_R   = 10;
  localparam int PW_F   = 20;

  logic              PCLK    = 1'b0;
  logic              PRESERN = 1'b0;
  logic              PSEL    = 1'b0;
  logic              PENABLE = 1'b0;
  logic              PWRITE  = 1'b0;
  logic [31:0]       PADDR   = '0;
  logic [31:0]       PWDATA  = '0;
  logic [31:0]       PRDATA;
  logic              PREADY;
  logic              PSLVERR;
  logic [NUM_CH-1:0] servo_pwm;

  servo_array_ctrl #(
    .NUM_CH     (NUM_CH),
    .CNT_W      (CNT_W),
    .PERIOD_CYC (PERIOD),
    .PW_NEUTRAL (PW_N),
    .PW_REVERSE (PW_R),
    .PW_FORWARD (PW_F)
  ) dut (
    .PCLK      (PCLK),
    .PRESERN   (PRESERN),
    .PSEL      (PSEL),
    .PENABLE   (PENABLE),
    .PWRITE    (PWRITE),
    .PADDR     (PADDR),
    .PWDATA    (PWDATA),
    .PRDATA    (PRDATA),
    .PREADY    (PREADY),
    .PSLVERR   (PSLVERR),
    .servo_pwm (servo_pwm)
  );

  always #5 PCLK = ~PCLK;

  typedef struct {
    int frame;
    int w0;
    int w1;
  } exp_t;

  exp_t exp_q[$];
  exp_t e_mon;
  int   n_assert = 0;
  int   n_fail   = 0;
  int   cyc      = 0;   // clock edges since reset release
  int   hi0      = 0;
  int   hi1      = 0;
  int   m_mon    = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  // Frame m spans edges 100m+1 .. 100m+100; high-cycle counts are the widths
  always begin
    @(posedge PCLK);
    #1;
    if (!PRESERN) begin
      cyc = 0;
      hi0 = 0;
      hi1 = 0;
    end else begin
      cyc++;
      hi0 = hi0 + int'(servo_pwm[0]);
      hi1 = hi1 + int'(servo_pwm[1]);
      if (cyc % PERIOD == 0) begin
        m_mon = cyc / PERIOD - 1;
        while (exp_q.size() > 0 && exp_q[0].frame <= m_mon) begin
          e_mon = exp_q.pop_front();
          chk($sformatf("frame%0d_ch0_width", e_mon.frame), 32'(hi0), 32'(e_mon.w0));
          chk($sformatf("frame%0d_ch1_width", e_mon.frame), 32'(hi1), 32'(e_mon.w1));
        end
        hi0 = 0;
        hi1 = 0;
      end
    end
  end

  task automatic expect_frames(input int first, input int n, input int w0, input int w1);
    exp_t e;
    for (int k = 0; k < n; k++) begin
      e.frame = first + k;
      e.w0    = w0;
      e.w1    = w1;
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge PCLK);
  endtask

  task automatic apb_write(input logic [31:0] a, input logic [31:0] d,
                           input logic exp_err, input string tag);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = a; PWDATA = d;
    @(negedge PCLK);
    PENABLE = 1'b1;
    #1;
    chk({tag, "_pslverr"}, {31'b0, PSLVERR}, {31'b0, exp_err});
    @(negedge PCLK);
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic apb_read(input logic [31:0] a, input logic [31:0] expd,
                          input logic exp_err, input string tag);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = a;
    @(negedge PCLK);
    PENABLE = 1'b1;
    #1;
    chk({tag, "_data"}, PRDATA, expd);
    chk({tag, "_pslverr"}, {31'b0, PSLVERR}, {31'b0, exp_err});
    @(negedge PCLK);
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (3) @(negedge PCLK);
    chk("reset_pwm", 32'(servo_pwm), 32'd0);
    chk("reset_prdata", PRDATA, 32'd0);
    chk("reset_pslverr", {31'b0, PSLVERR}, 32'd0);
    PRESERN = 1'b1;
    expect_frames(0, 2, PW_N, PW_N);

    wait_until(50);
    apb_read(32'h08, 32'd0, 1'b0, "pos0_reset");
    apb_read(32'h18, 32'd0, 1'b0, "pos1_reset");
    apb_read(32'h80, 32'd1, 1'b0, "ctrl_reset");
    apb_read(32'h88, 32'd0, 1'b0, "slew_reset");
    apb_read(32'h00, 32'(PW_N), 1'b0, "tgt0_reset");
    apb_read(32'h84, 32'd0, 1'b0, "frame_reset");

    // Ch0 forward for three frames, then return to zero
    wait_until(150);
    apb_write(32'h04, 32'd2, 1'b0, "cmd_fwd");
    expect_frames(2, 3, PW_F, PW_N);

    wait_until(450);
    apb_read(32'h08, 32'd3, 1'b0, "pos0_after_fwd");
    apb_read(32'h0C, 32'd0, 1'b0, "status0_run");
    apb_write(32'h04, 32'd5, 1'b0, "cmd_rtz");
    expect_frames(5, 3, PW_R, PW_N);
    expect_frames(8, 2, PW_N, PW_N);

    wait_until(550);
    apb_read(32'h0C, 32'd1, 1'b0, "status0_rtz_a");
    apb_read(32'h08, 32'd2, 1'b0, "pos0_rtz_a");

    // Error responses during ch0 RTZ; none may change state
    wait_until(650);
    apb_write(32'h00, 32'd18, 1'b1, "tgt_busy_err");
    apb_write(32'h04, 32'd1, 1'b1, "cmd_busy_err");
    apb_read(32'h28, 32'd0, 1'b1, "ch2_read_err");
    apb_write(32'h08, 32'd5, 1'b1, "pos_ro_err");
    apb_write(32'h14, 32'd7, 1'b1, "cmd_bad_err");
    apb_write(32'h84, 32'd3, 1'b1, "frame_ro_err");
    apb_read(32'h8C, 32'd0, 1'b1, "unmapped_err");
    apb_read(32'h0C, 32'd1, 1'b0, "status0_rtz_b");
    apb_read(32'h08, 32'd1, 1'b0, "pos0_rtz_b");
    apb_read(32'h00, 32'(PW_F), 1'b0, "tgt0_unchanged");
    apb_read(32'h10, 32'(PW_N), 1'b0, "tgt1_unchanged");

    wait_until(750);
    apb_read(32'h0C, 32'd1, 1'b0, "status0_rtz_c");
    apb_read(32'h08, 32'd0, 1'b0, "pos0_rtz_c");

    wait_until(850);
    apb_read(32'h0C, 32'd0, 1'b0, "status0_done");
    apb_read(32'h00, 32'(PW_N), 1'b0, "tgt0_after_rtz");

    // Slew limited move on ch1
    wait_until(950);
    apb_write(32'h88, 32'd2, 1'b0, "slew_wr");
    apb_write(32'h10, 32'd20, 1'b0, "tgt1_fwd");
    expect_frames(10, 1, PW_N, 17);
    expect_frames(11, 1, PW_N, 19);
    expect_frames(12, 1, PW_N, PW_F);

    wait_until(1050);
    apb_read(32'h1C, 32'd2, 1'b0, "status1_slewing");
    apb_read(32'h88, 32'd2, 1'b0, "slew_rd");

    wait_until(1250);
    apb_read(32'h1C, 32'd0, 1'b0, "status1_settled");
    apb_write(32'h10, 32'd5, 1'b0, "tgt1_low");
    apb_read(32'h10, 32'(PW_R), 1'b0, "tgt1_clamp_min");
    apb_write(32'h10, 32'd999, 1'b0, "tgt1_high");
    apb_read(32'h10, 32'(PW_F), 1'b0, "tgt1_clamp_max");
    expect_frames(13, 3, PW_N, PW_F);

    wait_until(1350);
    apb_read(32'h18, 32'd2, 1'b0, "pos1_fwd");

    // Zero position committed exactly on the boundary edge
    wait_until(1398);
    apb_write(32'h14, 32'd4, 1'b0, "cmd_zero_boundary");

    wait_until(1450);
    apb_read(32'h18, 32'd0, 1'b0, "pos1_zero_wins");
    apb_read(32'h08, 32'd0, 1'b0, "pos0_idle");

    // Outputs disabled for one frame; trackers keep running
    wait_until(1550);
    apb_write(32'h80, 32'd0, 1'b0, "ctrl_off");
    apb_read(32'h80, 32'd0, 1'b0, "ctrl_off_rd");
    expect_frames(16, 1, 0, 0);

    wait_until(1650);
    apb_write(32'h80, 32'd1, 1'b0, "ctrl_on");
    expect_frames(17, 1, PW_N, PW_F);

    wait_until(1750);
    apb_read(32'h18, 32'd3, 1'b0, "pos1_while_off");
    apb_read(32'h84, 32'd17, 1'b0, "frame_count");

    // Asynchronous reset in the middle of a pulse
    wait_until(1805);
    chk("pwm_mid_pulse", 32'(servo_pwm), 32'd3);
    PRESERN = 1'b0;
    #1;
    chk("pwm_async_reset", 32'(servo_pwm), 32'd0);
    repeat (3) @(negedge PCLK);
    PRESERN = 1'b1;
    expect_frames(0, 2, PW_N, PW_N);

    wait_until(50);
    apb_read(32'h88, 32'd0, 1'b0, "slew_after_reset");
    apb_read(32'h18, 32'd0, 1'b0, "pos1_after_reset");
    apb_read(32'h10, 32'(PW_N), 1'b0, "tgt1_after_reset");
    apb_read(32'h80, 32'd1, 1'b0, "ctrl_after_reset");

    wait_until(202);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
